// File: rtl/bam_mac_pkg.sv
// bam_mac_pkg: shared state enum, default widths and count-width helper for the BAM MAC accumulator
package bam_mac_pkg;
  typedef enum logic {ACC, DONE} state_t;
  localparam int DEF_PROD_W    = 16;
  localparam int DEF_ACC_W     = 24;
  localparam int DEF_DROP_LSB  = 9;
  localparam int DEF_MAX_TERMS = 256;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/bam_mac_add.sv
// bam_mac_add: W-bit adder (a, b -> sum, co); sum saturates to all ones on carry out when BAM_MAC_SAT_EN is defined, else wraps
module bam_mac_add #(
  parameter int W = 15
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         co
);
  logic [W-1:0] raw;
  assign {co, raw} = {1'b0, a} + {1'b0, b};
`ifdef BAM_MAC_SAT_EN
  assign sum = co ? '1 : raw;
`else
  assign sum = raw;
`endif
endmodule

// File: rtl/bam_mac_accumulator.sv
// bam_mac_accumulator: frame MAC accumulator (clk, async rst, in valid/ready/prod/last, out valid/ready/acc/terms/ovf/forced); BAM_MAC_SAT_EN selects saturation
module bam_mac_accumulator
  import bam_mac_pkg::*;
#(
  parameter int PROD_W    = DEF_PROD_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int DROP_LSB  = DEF_DROP_LSB,
  parameter int MAX_TERMS = DEF_MAX_TERMS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PROD_W-1:0]              in_prod,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_W-1:0]               out_acc,
  output logic [cnt_w(MAX_TERMS)-1:0]    out_terms,
  output logic                           out_ovf,
  output logic                           out_forced
);
  localparam int AW = ACC_W - DROP_LSB;
  localparam int CW = cnt_w(MAX_TERMS);
  state_t state, state_n;
  logic [AW-1:0] acc, sum;
  logic [CW-1:0] cnt, cnt_inc;
  logic ovf, co, accept, hit_max, close, done_hs;
  bam_mac_add #(.W(AW)) u_add (
    .a  (acc),
    .b  (AW'(in_prod[PROD_W-1:DROP_LSB])),
    .sum(sum),
    .co (co)
  );
  assign in_ready  = state == ACC;
  assign out_valid = state == DONE;
  assign accept    = in_valid & in_ready;
  assign cnt_inc   = cnt + 1'b1;
  assign hit_max   = cnt_inc == CW'(MAX_TERMS);
  assign close     = accept & (in_last | hit_max);
  assign done_hs   = out_valid & out_ready;
  always_comb state_n = close ? DONE : done_hs ? ACC : state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACC;
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      out_acc    <= '0;
      out_terms  <= '0;
      out_ovf    <= 1'b0;
      out_forced <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        acc <= sum;
        cnt <= cnt_inc;
        ovf <= ovf | co;
      end
      if (close) begin
        out_acc    <= {sum, {DROP_LSB{1'b0}}};
        out_terms  <= cnt_inc;
        out_ovf    <= ovf | co;
        out_forced <= hit_max & ~in_last;
      end
      if (done_hs) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
    end
  end
  a_low_zero: assert property (@(posedge clk) disable iff (rst)
    accept |-> in_prod[DROP_LSB-1:0] == '0);
endmodule
